fp_alu_seq: RTL and testbench

FP_ALU_SEQ -- requirements
Module: fp_alu_seq

---
 rtl/fp_alu_seq.sv | 184 ++++++++++++++++++
 tb/tb_fp_alu_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_seq.sv
// Sequential FP ALU front-end: serial operand load, external execution handshake, serial result drain.
// Optional macro FP_ALU_SEQ_TIMEOUT_EN adds a WAIT-state timeout that aborts to IDLE with err set.
module fp_alu_seq #(
  parameter int DATA_W  = 32,
  parameter int BUS_W   = 8,
  parameter int OPC_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [BUS_W-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [OPC_W-1:0]  ex_op,
  output logic              ex_req,
  input  logic              ex_ack,
  input  logic [DATA_W-1:0] ex_result,
  output logic [BUS_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              err,
  output logic [2:0]        state_out
);

  localparam int N     = DATA_W / BUS_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((TIMEOUT < 1) || (N < 1) || ((DATA_W % BUS_W) != 0)) begin : g_bad_cfg
    $error("fp_alu_seq: invalid parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OPC_W-1:0]  op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [31:0]       idx;
  logic              beat_in, beat_out, cnt_last;

`ifdef FP_ALU_SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;
`endif

  assign idx      = 32'(cnt_q) * 32'(BUS_W);
  assign cnt_last = (cnt_q == LAST);
  assign in_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign beat_in  = in_valid & in_ready;
  assign out_valid = (state_q == S_OUT);
  assign beat_out = out_valid & out_ready;
  assign out_last = out_valid & cnt_last;
  assign out_data = out_valid ? res_q[idx +: BUS_W] : '0;
  assign ex_req   = (state_q == S_EXEC);
  assign ex_a     = a_q;
  assign ex_b     = b_q;
  assign ex_op    = op_q;
  assign busy     = (state_q != S_IDLE);
  assign state_out = state_q;
`ifdef FP_ALU_SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
`ifdef FP_ALU_SEQ_TIMEOUT_EN
    tmr_d   = '0;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = opcode;
          cnt_d   = '0;
`ifdef FP_ALU_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (beat_in) begin
          a_d[idx +: BUS_W] = in_data;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        if (beat_in) begin
          b_d[idx +: BUS_W] = in_data;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = S_EXEC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_EXEC: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An ack on the final timeout cycle still wins over the abort
        if (ex_ack) begin
          res_d   = ex_result;
          cnt_d   = '0;
          state_d = S_OUT;
        end
`ifdef FP_ALU_SEQ_TIMEOUT_EN
        else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
`endif
      end
      S_OUT: begin
        if (beat_out) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
`ifdef FP_ALU_SEQ_TIMEOUT_EN
      tmr_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
`ifdef FP_ALU_SEQ_TIMEOUT_EN
      tmr_q   <= tmr_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_alu_seq.sv
// Directed bench for fp_alu_seq: vector table on an 8-bit-bus instance plus
// hand sequences for reset abort, WAIT behaviour and a 16-bit-bus instance.
module tb_fp_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  opcode;
  logic [7:0]  in_data;
  logic        in_valid, in_ready;
  logic [31:0] ex_a, ex_b, ex_result;
  logic [1:0]  ex_op;
  logic        ex_req, ex_ack;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_last, busy, err;
  logic [2:0]  state_out;

  logic        start2;
  logic [1:0]  opcode2;
  logic [15:0] in_data2;
  logic        in_valid2, in_ready2;
  logic [31:0] ex_a2, ex_b2, ex_result2;
  logic [1:0]  ex_op2;
  logic        ex_req2, ex_ack2;
  logic [15:0] out_data2;
  logic        out_valid2, out_ready2, out_last2, busy2, err2;
  logic [2:0]  state_out2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fp_alu_seq #(.DATA_W(32), .BUS_W(8), .OPC_W(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ex_a(ex_a), .ex_b(ex_b), .ex_op(ex_op), .ex_req(ex_req),
    .ex_ack(ex_ack), .ex_result(ex_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .err(err), .state_out(state_out)
  );

  fp_alu_seq #(.DATA_W(32), .BUS_W(16), .OPC_W(2), .TIMEOUT(16)) dut16 (
    .clk(clk), .rst(rst), .start(start2), .opcode(opcode2),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .ex_a(ex_a2), .ex_b(ex_b2), .ex_op(ex_op2), .ex_req(ex_req2),
    .ex_ack(ex_ack2), .ex_result(ex_result2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_last(out_last2),
    .busy(busy2), .err(err2), .state_out(state_out2)
  );

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  alt_op;     // opcode driven after start
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          gap_beat;   // input beat preceded by a 2-cycle in_valid gap (-1 none)
    int          stall_beat; // output beat held with out_ready low 3 cycles (-1 none)
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input int gap);
    int k;
    for (int g = 0; g < gap; g++) begin
      in_valid  = 1'b0;
      in_data   = 8'hA5;
      ex_ack    = 1'b1;          // stray ack while loading must be ignored
      ex_result = 32'hBAD0BAD0;
      @(negedge clk);
    end
    ex_ack   = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h5A;
  endtask

  task automatic load_operands(input logic [31:0] a, input logic [31:0] b, input int gap_beat);
    logic [63:0] ab;
    ab = {b, a};
    for (int j = 0; j < 8; j++)
      send_beat(ab[j*8 +: 8], (j == gap_beat) ? 2 : 0);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [31:0] r;
    start  = 1'b1;
    opcode = v.op;
    @(negedge clk);
    start  = 1'b0;
    opcode = v.alt_op;
    check($sformatf("v%0d_state_load_a", n), {61'd0, state_out}, 64'd1);
    load_operands(v.a, v.b, v.gap_beat);
    check($sformatf("v%0d_ex_req_latency", n), {63'd0, ex_req}, 64'd1);
    check($sformatf("v%0d_ex_a", n), {32'd0, ex_a}, {32'd0, v.a});
    check($sformatf("v%0d_ex_b", n), {32'd0, ex_b}, {32'd0, v.b});
    check($sformatf("v%0d_ex_op", n), {62'd0, ex_op}, {62'd0, v.op});
    @(negedge clk);
    check($sformatf("v%0d_ex_req_one_cycle", n), {63'd0, ex_req}, 64'd0);
    check($sformatf("v%0d_state_wait", n), {61'd0, state_out}, 64'd4);
    @(negedge clk);
    @(negedge clk);
    ex_ack    = 1'b1;
    ex_result = v.res;
    check($sformatf("v%0d_ex_a_stable", n), {32'd0, ex_a}, {32'd0, v.a});
    check($sformatf("v%0d_ex_op_stable", n), {62'd0, ex_op}, {62'd0, v.op});
    @(negedge clk);
    ex_ack    = 1'b0;
    ex_result = ~v.res;
    check($sformatf("v%0d_out_valid_latency", n), {63'd0, out_valid}, 64'd1);
    r = v.res;
    for (int i = 0; i < 4; i++) begin
      if (i == v.stall_beat) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          check($sformatf("v%0d_hold_beat%0d", n, i), {56'd0, out_data}, {56'd0, r[i*8 +: 8]});
          @(negedge clk);
        end
      end
      check($sformatf("v%0d_out_valid%0d", n, i), {63'd0, out_valid}, 64'd1);
      check($sformatf("v%0d_out_data%0d", n, i), {56'd0, out_data}, {56'd0, r[i*8 +: 8]});
      check($sformatf("v%0d_out_last%0d", n, i), {63'd0, out_last}, {63'd0, (i == 3)});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    check($sformatf("v%0d_idle_after", n), {61'd0, state_out}, 64'd0);
    check($sformatf("v%0d_busy_after", n), {63'd0, busy}, 64'd0);
    check($sformatf("v%0d_no_extra_valid", n), {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vecs[0] = '{op: 2'b00, alt_op: 2'b00, a: 32'h3F800000, b: 32'h40000000, res: 32'h40400000, gap_beat: -1, stall_beat: -1};
    vecs[1] = '{op: 2'b00, alt_op: 2'b11, a: 32'h3F800000, b: 32'h40000000, res: 32'h40400000, gap_beat: 1,  stall_beat: 2};
    vecs[2] = '{op: 2'b01, alt_op: 2'b10, a: 32'h12345678, b: 32'h9ABCDEF0, res: 32'hDEADBEEF, gap_beat: -1, stall_beat: -1};
    vecs[3] = '{op: 2'b11, alt_op: 2'b00, a: 32'hFFFFFFFF, b: 32'h00000001, res: 32'h00000000, gap_beat: 4,  stall_beat: 3};

    rst = 1'b1; start = 1'b0; opcode = '0; in_data = '0; in_valid = 1'b0;
    ex_ack = 1'b0; ex_result = '0; out_ready = 1'b0;
    start2 = 1'b0; opcode2 = '0; in_data2 = '0; in_valid2 = 1'b0;
    ex_ack2 = 1'b0; ex_result2 = '0; out_ready2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", {61'd0, state_out}, 64'd0);
    check("rst_outputs", {57'd0, in_ready, ex_req, out_valid, out_last, busy, err, 1'b0}, 64'd0);
    check("rst_out_data", {56'd0, out_data}, 64'd0);
    check("rst_ex_a_b", {ex_a, ex_b}, 64'd0);
    check("rst_ex_op", {62'd0, ex_op}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) run_vec(vecs[v], v);

    // Reset during the second B beat, then a late ack
    start = 1'b1; opcode = 2'b10;
    @(negedge clk);
    start = 1'b0;
    load_operands(32'h11223344, 32'h55667788, -1 + 99);
    cnt = 0;
    check("abort_precheck_state", {61'd0, state_out}, 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1; opcode = 2'b01;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 5; j++) send_beat(8'h10 + 8'(j), 0);
    in_data = 8'hEE; in_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; ex_ack = 1'b1; ex_result = 32'hCAFEF00D;
    check("abort_state", {61'd0, state_out}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd0);
    check("abort_ex_a_cleared", {32'd0, ex_a}, 64'd0);
    @(negedge clk);
    ex_ack = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (out_valid || ex_req || busy) cnt++;
      @(negedge clk);
    end
    check("abort_no_activity", cnt, 64'd0);

    // Long WAIT without ack
    start = 1'b1; opcode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    load_operands(32'h3F800000, 32'h40000000, -1);
    check("wait_ex_req", {63'd0, ex_req}, 64'd1);
    cnt = 0;
`ifdef FP_ALU_SEQ_TIMEOUT_EN
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("to_still_wait", {61'd0, state_out}, 64'd4);
    check("to_err_before", {63'd0, err}, 64'd0);
    @(negedge clk);
    check("to_idle", {61'd0, state_out}, 64'd0);
    check("to_err_set", {63'd0, err}, 64'd1);
    for (int j = 0; j < 5; j++) begin
      if (out_valid) cnt++;
      @(negedge clk);
    end
    check("to_no_out_valid", cnt, 64'd0);
    check("to_err_held", {63'd0, err}, 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("to_err_cleared", {63'd0, err}, 64'd0);
    check("to_restart_state", {61'd0, state_out}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`else
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("nto_still_wait", {61'd0, state_out}, 64'd4);
    check("nto_err_zero", {63'd0, err}, 64'd0);
    check("nto_no_out_valid", cnt, 64'd0);
    ex_ack = 1'b1; ex_result = 32'hA1B2C3D4;
    @(negedge clk);
    ex_ack = 1'b0;
    out_ready = 1'b1;
    check("nto_beat0", {56'd0, out_data}, 64'hD4);
    @(negedge clk);
    check("nto_beat1", {56'd0, out_data}, 64'hC3);
    @(negedge clk);
    check("nto_beat2", {56'd0, out_data}, 64'hB2);
    @(negedge clk);
    check("nto_beat3", {56'd0, out_data}, 64'hA1);
    check("nto_last", {63'd0, out_last}, 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
    check("nto_idle", {61'd0, state_out}, 64'd0);
`endif

    // 16-bit bus instance
    start2 = 1'b1; opcode2 = 2'b01;
    @(negedge clk);
    start2 = 1'b0; opcode2 = 2'b00;
    in_valid2 = 1'b1;
    in_data2 = 16'h0000; @(negedge clk);
    in_data2 = 16'h3F80; @(negedge clk);
    in_data2 = 16'h0000; @(negedge clk);
    in_data2 = 16'h4000; @(negedge clk);
    in_valid2 = 1'b0;
    check("w16_ex_req", {63'd0, ex_req2}, 64'd1);
    check("w16_ex_a", {32'd0, ex_a2}, 64'h3F800000);
    check("w16_ex_b", {32'd0, ex_b2}, 64'h40000000);
    check("w16_ex_op", {62'd0, ex_op2}, 64'd1);
    @(negedge clk);
    ex_ack2 = 1'b1; ex_result2 = 32'h40400000;
    @(negedge clk);
    ex_ack2 = 1'b0;
    check("w16_beat0", {48'd0, out_data2}, 64'h0000);
    check("w16_last0", {63'd0, out_last2}, 64'd0);
    out_ready2 = 1'b1;
    @(negedge clk);
    check("w16_beat1", {48'd0, out_data2}, 64'h4040);
    check("w16_last1", {63'd0, out_last2}, 64'd1);
    @(negedge clk);
    out_ready2 = 1'b0;
    check("w16_idle", {61'd0, state_out2}, 64'd0);
    check("w16_no_valid", {63'd0, out_valid2}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
